// File: rtl/shft_arbiter_pkg.sv
// Shared types and the shift helper for the shared-shifter arbiter.
package shft_arb_pkg;
  localparam int A_W = 4;
  localparam int B_W = 4;
  localparam int C_W = 8;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  // Zero-extend then shift; shift amounts >= C_W fall off the top and give 0.
  function automatic logic [C_W-1:0] shift_trunc(input logic [A_W-1:0] a,
                                                 input logic [B_W-1:0] b);
    logic [C_W-1:0] ext;
    ext = {{(C_W-A_W){1'b0}}, a};
    return ext << b;
  endfunction
endpackage

// File: rtl/shft_arbiter_if.sv
// Request/response bundle between the clients and the shared shifter.
interface shft_arbiter_if #(parameter int N_REQ = 4);
  import shft_arb_pkg::*;
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]     req_valid_i;
  logic [N_REQ*A_W-1:0] req_a_i;
  logic [N_REQ*B_W-1:0] req_b_i;
  logic [N_REQ-1:0]     req_ready_o;
  logic [N_REQ-1:0]     rsp_valid_o;
  logic [N_REQ-1:0]     rsp_ready_i;
  logic [C_W-1:0]       rsp_data_o;
  logic [ID_W-1:0]      rsp_id_o;
  logic                 busy_o;

  modport master (output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
                  input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o, busy_o);
  modport slave  (input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
                  output req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o, busy_o);
endinterface

// File: rtl/shft_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_valid
);
  always_comb begin
    int k;
    k         = 0;
    gnt_idx   = '0;
    any_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any_valid && req[k]) begin
        any_valid = 1'b1;
        gnt_idx   = IW'(k);
      end
    end
    gnt = any_valid ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/shft_arbiter.sv
// Round-robin arbiter sharing one shifter; holds one result until its owner accepts it.
module shft_arbiter
  import shft_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  shft_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(N_REQ);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr, owner_q, gnt_idx;
  logic [N_REQ-1:0]  gnt, rsp_valid_q;
  logic [C_W-1:0]    res_q;
  logic              any_valid;
  logic [A_W-1:0]    a_sel;
  logic [B_W-1:0]    b_sel;

  rr_pick #(.N(N_REQ), .IW(ID_W)) u_pick (
    .req       (bus.req_valid_i),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .any_valid (any_valid)
  );

  assign a_sel = bus.req_a_i[int'(gnt_idx)*A_W +: A_W];
  assign b_sel = bus.req_b_i[int'(gnt_idx)*B_W +: B_W];

  // Grant is gated by reset so nothing is offered while the block is held in reset.
  assign bus.req_ready_o = (state == IDLE && rst_ni) ? gnt : '0;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = res_q;
  assign bus.rsp_id_o    = owner_q;
  assign bus.busy_o      = (state == RESP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner_q     <= '0;
      res_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          res_q       <= shift_trunc(a_sel, b_sel);
          owner_q     <= gnt_idx;
          rr_ptr      <= (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
          rsp_valid_q <= gnt;
          state       <= RESP;
        end
        RESP: if (bus.rsp_ready_i[owner_q]) begin
          rsp_valid_q <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shft_arbiter.sv
// Bench for shft_arbiter: directed scenarios plus random traffic vs a behavioural model.
module tb_shft_arbiter;
  import shft_arb_pkg::*;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shft_arbiter_if #(.N_REQ(N)) bus();
  shft_arbiter #(.N_REQ(N)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pending-result flag, owner, pointer and value
  bit       m_busy  = 0;
  int       m_owner = 0;
  int       m_ptr   = 0;
  int       m_res   = 0;

  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++)
      if (v[(ptr + i) % N] === 1'b1) return (ptr + i) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_res = 0;
    end else if (!m_busy) begin
      int g;
      g = model_pick(bus.req_valid_i, m_ptr);
      if (g >= 0) begin
        int a, b;
        a = int'(bus.req_a_i[g*A_W +: A_W]);
        b = int'(bus.req_b_i[g*B_W +: B_W]);
        m_res   = (b >= C_W) ? 0 : (a * (1 << b)) % (1 << C_W);
        m_owner = g;
        m_ptr   = (g + 1) % N;
        m_busy  = 1;
      end
    end else if (bus.rsp_ready_i[m_owner]) begin
      m_busy = 0;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy, exp_vld;
    int g;
    g = model_pick(bus.req_valid_i, m_ptr);
    exp_rdy = (!rst_n || m_busy || g < 0) ? '0 : (N'(1) << g);
    exp_vld = m_busy ? (N'(1) << m_owner) : '0;
    chk("req_ready", 32'(bus.req_ready_o), 32'(exp_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(exp_vld));
    chk("busy", 32'(bus.busy_o), 32'(m_busy));
    chk("rsp_id", 32'(bus.rsp_id_o), 32'(m_owner));
    if (m_busy) chk("rsp_data", 32'(bus.rsp_data_o), 32'(m_res));
  end

  logic [N-1:0]     va;
  logic [N*A_W-1:0] pa;
  logic [N*B_W-1:0] pb;

  task automatic drive();
    bus.req_valid_i = va; bus.req_a_i = pa; bus.req_b_i = pb;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int order[$];
    int when[$];
    int exp_order[5];
    logic [3:0] wb[4];
    logic [7:0] wr[4];
    logic [N-1:0] rdy_s;

    exp_order = '{0, 1, 2, 3, 0};
    wb = '{4'd4, 4'd5, 4'd8, 4'd15};
    wr = '{8'hF0, 8'hE0, 8'h00, 8'h00};

    va = '1; pa = 16'h1234; pb = 16'h1111; drive();
    bus.rsp_ready_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready_o), 0);
    chk("rst_valid", 32'(bus.rsp_valid_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    step(); va = '0; drive(); rst_n = 1'b1;
    step();

    // Single op from requester 0
    va = 4'b0001; pa = 16'h000B; pb = 16'h0002; drive();
    @(negedge clk); chk("single_grant", 32'(bus.req_ready_o), 32'b0001);
    step(); va = '0; drive();
    @(negedge clk);
    chk("single_vld", 32'(bus.rsp_valid_o), 32'b0001);
    chk("single_data", 32'(bus.rsp_data_o), 32'h2C);
    chk("single_id", 32'(bus.rsp_id_o), 0);
    bus.rsp_ready_i = 4'b0001;
    step(); bus.rsp_ready_i = '0;

    // Reset while a result is held
    va = 4'b0010; pa = 16'h0030; pb = 16'h0010; drive();
    step(); va = '0; drive();
    @(negedge clk); chk("pre_rst_vld", 32'(bus.rsp_valid_o), 32'b0010);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_vld", 32'(bus.rsp_valid_o), 0);
    chk("mid_rst_busy", 32'(bus.busy_o), 0);
    step(); rst_n = 1'b1;
    bus.rsp_ready_i = '1;
    repeat (3) begin
      @(negedge clk); chk("post_rst_vld", 32'(bus.rsp_valid_o), 0);
    end
    step();

    // Round-robin with everyone requesting continuously
    va = '1; pa = 16'h4321; pb = 16'h0123; drive(); bus.rsp_ready_i = '1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.req_ready_o != 0) begin
        order.push_back(oh_idx(bus.req_ready_o)); when.push_back(c);
      end
    end
    step(); va = '0; drive();
    chk("rr_count", 32'(order.size()), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      chk("rr_order", 32'(order[i]), 32'(exp_order[i]));
      chk("rr_spacing", 32'(when[i]), 32'(2*i));
    end

    // Backpressure on requester 1 (pointer is now 1)
    va = 4'b0010; pa = 16'h0050; pb = 16'h0030; drive(); bus.rsp_ready_i = 4'b1101;
    @(negedge clk); chk("bp_grant", 32'(bus.req_ready_o), 32'b0010);
    step(); va = '1; drive();
    repeat (5) begin
      @(negedge clk);
      chk("bp_vld", 32'(bus.rsp_valid_o), 32'b0010);
      chk("bp_data", 32'(bus.rsp_data_o), 32'h28);
      chk("bp_ready", 32'(bus.req_ready_o), 0);
      step();
    end
    va = '0; drive(); bus.rsp_ready_i = 4'b0010;
    step(); bus.rsp_ready_i = '1;

    // Pointer wrap/skip: move pointer to 3, then only req1, then req0+req3
    va = 4'b0100; drive(); step(); va = '0; drive(); step();
    va = 4'b0010; drive();
    @(negedge clk); chk("wrap_grant1", 32'(bus.req_ready_o), 32'b0010);
    step(); va = '0; drive(); step();
    va = 4'b1001; drive();
    @(negedge clk); chk("skip_grant3", 32'(bus.req_ready_o), 32'b1000);
    step(); va = '0; drive(); step();

    // Width edges on requester 0
    for (int i = 0; i < 4; i++) begin
      va = 4'b0001; pa = 16'h000F; pb = {12'h0, wb[i]}; drive();
      step(); va = '0; drive();
      @(negedge clk); chk("width_edge", 32'(bus.rsp_data_o), 32'(wr[i]));
      step();
    end

    // Random traffic; operands held stable while waiting for a grant
    va = '0; drive();
    repeat (1500) begin
      @(negedge clk); rdy_s = bus.req_ready_o;
      step();
      for (int k = 0; k < N; k++) begin
        if (va[k] && !rdy_s[k]) begin
          if ($urandom_range(7) == 0) va[k] = 1'b0;
        end else begin
          va[k] = ($urandom_range(2) == 0);
          pa[k*A_W +: A_W] = 4'($urandom);
          pb[k*B_W +: B_W] = 4'($urandom);
        end
      end
      drive();
      bus.rsp_ready_i = 4'($urandom);
    end
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shft_arbiter.md
Name: shft_arbiter

Overview:
Shares one 4-bit left-shift datapath (8-bit result) between N_REQ requesters. Arbitration is round-robin, with a valid/ready handshake on both the request side and the response side. The block holds one operation at a time and returns the result in a register. It sits between the lab's control logic (e.g. switch/FSM front-ends) and the shift unit, so several clients can use one shifter instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
A_W, 4, operand a width
B_W, 4, shift-amount width
C_W, 8, result width (2*A_W)
ID_W, $clog2(N_REQ), requester-index width (derived, not overridden)

Ports:
clk_i  input  1  rising-edge clock
rst_ni  input  1  asynchronous active-low reset
req_valid_i  input  N_REQ  per-requester request valid
req_a_i  input  N_REQ*A_W  packed operand a; requester k uses bits [k*A_W +: A_W]
req_b_i  input  N_REQ*B_W  packed shift amount; requester k uses bits [k*B_W +: B_W]
req_ready_o  output  N_REQ  one-hot grant/accept
rsp_valid_o  output  N_REQ  one-hot result valid to the owning requester
rsp_ready_i  input  N_REQ  per-requester result accept
rsp_data_o  output  C_W  shared result bus
rsp_id_o  output  ID_W  index of the owning requester
busy_o  output  1  high while a result is held

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, res_q=0, owner_q=0. While reset is asserted, all outputs are 0.
- Reset mid-operation discards any held result. No rsp_valid_o is produced for it after release.
- FSM has two states, IDLE and RESP.
- IDLE behaviour:
  - grant = first requester with req_valid_i set, searching from rr_ptr upward and wrapping at N_REQ-1 -> 0.
  - req_ready_o = onehot(grant) combinationally, only when at least one valid is set; otherwise 0.
  - Handshake on a clock edge: res_q <= ({{(C_W-A_W){0}},a} << b) truncated to C_W; owner_q <= grant; rr_ptr <= (grant+1) mod N_REQ; next state RESP.
  - req_ready_o never depends on rsp_ready_i.
- RESP behaviour:
  - rsp_valid_o = onehot(owner_q); rsp_data_o = res_q; rsp_id_o = owner_q; busy_o=1; req_ready_o=0.
  - When rsp_ready_i[owner_q]=1: next state IDLE, result dropped.
  - rsp_ready_i bits of non-owners are ignored.
- In IDLE: rsp_valid_o=0, busy_o=0, rsp_data_o holds its last value (not required to be 0), rsp_id_o=owner_q.
- Latency: request accepted at edge N; rsp_valid_o high from N+1. With rsp_ready_i held at 1, the next grant occurs at N+2, so peak throughput is 1 op per 2 cycles.
- Width rules:
  - a is zero-extended before shifting.
  - b >= C_W gives result 0.
  - b in [A_W, C_W) gives partial truncation of the high bits of a.
- Requesters must hold req_a/req_b stable while valid and not ready. A requester that drops valid before being granted is simply skipped.
- Simultaneous events: a requester granted in one op keeps requesting and another requester is also waiting -> the other requester wins next, because rr_ptr has moved past the winner.
- rr_ptr advances only on an accepted handshake, never on idle cycles.

Decomposition:
- Package shft_arb_pkg holds:
  - state enum {IDLE, RESP};
  - localparams A_W=4, B_W=4, C_W=8;
  - function shift_trunc(a,b).
- Sub-module rr_pick (N parameter): inputs req vector and ptr; outputs one-hot grant, grant index, any_valid. It is purely combinational and reused by other lab arbiters.
- The shift expression is computed inline, or by instantiating the team's existing shifter on the granted operands.

Test Plan:
1. Reset: hold rst_ni=0 with all req_valid_i=1 -> req_ready_o=0, rsp_valid_o=0, busy_o=0. Assert rst_ni low in RESP -> rsp_valid_o drops immediately and stays 0 after release until a new grant.
2. Single op: req0 a=4'b1011, b=2 -> grant req_ready_o=0001 that cycle; next cycle rsp_valid_o=0001, rsp_data_o=8'h2C, rsp_id_o=0.
3. Round-robin: all four valid continuously, rsp_ready_i=1111 -> grant order 0,1,2,3,0, with grants every 2 cycles.
4. Backpressure: rsp_ready_i[1]=0 for 5 cycles after grant 1 -> rsp_valid_o=0010 and data stable for 5 cycles; req_ready_o=0 throughout; other rsp_ready bits ignored.
5. Width edge: a=4'hF with b=4 -> 8'hF0; b=5 -> 8'hE0; b=8 -> 8'h00; b=15 -> 8'h00.
6. Pointer wrap/skip: rr_ptr=3 with only req1 valid -> req1 granted; rr_ptr becomes 2. Then only req0 and req3 valid -> req3 granted first.
